// File: rtl/sub_seq.sv
// rtl/sub_seq.sv - chunk-serial subtractor diff = in0 - in1 - bin with valid/ready handshakes
// Optional status flags (zero/neg/ovf) are enabled by defining SUB_SEQ_FLAGS_EN.
module sub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_SEQ_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("sub_seq: WIDTH must be a non-zero exact multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_nxt;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             bout_q;
  logic [CHUNK:0]   chunk_res;
  logic             last;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it reads 0 for the whole time reset is held
  always_comb begin
    in_ready  = rst_n && (state == IDLE);
    out_valid = (state == DONE);
  end

  assign accept = in_valid && in_ready;
  assign last   = (cnt == LAST);

  // One chunk per cycle; the top bit of chunk_res is the borrow into the next chunk
  always_comb begin
    chunk_res = {1'b0, a_q[cnt*CHUNK +: CHUNK]} - {1'b0, b_q[cnt*CHUNK +: CHUNK]}
              - (CHUNK+1)'(borrow);
    diff_nxt = diff_q;
    diff_nxt[cnt*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_q    <= in0;
      b_q    <= in1;
      borrow <= bin;
      cnt    <= '0;
    end else if (state == BUSY) begin
      diff_q <= diff_nxt;
      borrow <= chunk_res[CHUNK];
      if (last) begin
        bout_q <= chunk_res[CHUNK];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

`ifdef SUB_SEQ_FLAGS_EN
  // Flags are taken from the completed result on the final chunk, alongside bout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      neg  <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == BUSY && last) begin
      zero <= (diff_nxt == '0);
      neg  <= diff_nxt[WIDTH-1];
      ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_sub_seq.sv
// tb/tb_sub_seq.sv - scoreboard bench for sub_seq at CHUNK=4 and CHUNK=32
module tb_sub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_in_valid, a_in_ready, a_bin, a_out_valid, a_out_ready, a_bout;
  logic [31:0] a_in0, a_in1, a_diff;
  logic        b_in_valid, b_in_ready, b_bin, b_out_valid, b_out_ready, b_bout;
  logic [31:0] b_in0, b_in1, b_diff;
`ifdef SUB_SEQ_FLAGS_EN
  logic        a_zero, a_neg, a_ovf, b_zero, b_neg, b_ovf;
`endif

  sub_seq #(.WIDTH(32), .CHUNK(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in0(a_in0), .in1(a_in1), .bin(a_bin), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .diff(a_diff), .bout(a_bout)
`ifdef SUB_SEQ_FLAGS_EN
    , .zero(a_zero), .neg(a_neg), .ovf(a_ovf)
`endif
  );

  sub_seq #(.WIDTH(32), .CHUNK(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in0(b_in0), .in1(b_in1), .bin(b_bin), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .diff(b_diff), .bout(b_bout)
`ifdef SUB_SEQ_FLAGS_EN
    , .zero(b_zero), .neg(b_neg), .ovf(b_ovf)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, neg, zero, bout, diff[31:0]}
  function automatic logic [35:0] ref_sub(input logic [31:0] x, input logic [31:0] y, input logic bi);
    logic [32:0] r;
    logic z, n, o;
    r = {1'b0, x} - {1'b0, y} - 33'(bi);
    z = (r[31:0] == 32'h0);
    n = r[31];
    o = (x[31] != y[31]) && (r[31] != x[31]);
    return {o, n, z, r};
  endfunction

  logic [35:0] qa[$];
  logic [35:0] qb[$];
  logic [35:0] ea, eb;
  int cyc = 0;
  int acc_a = 0, acc_b = 0;
  int last_a = -1, last_b = -1;
  logic stream_a = 1'b0, stream_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && a_in_valid && a_in_ready) begin
      qa.push_back(ref_sub(a_in0, a_in1, a_bin));
      acc_a++;
      if (stream_a && last_a >= 0) check_eq("a_interval", 64'(cyc - last_a), 64'd10);
      last_a = cyc;
    end
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        check_eq("a_spurious_out", 64'(a_out_valid), 64'd0);
      end else begin
        ea = qa.pop_front();
        check_eq("a_result", 64'({a_bout, a_diff}), 64'(ea[32:0]));
`ifdef SUB_SEQ_FLAGS_EN
        check_eq("a_flags", 64'({a_ovf, a_neg, a_zero}), 64'(ea[35:33]));
`endif
      end
    end
    if (rst_n && b_in_valid && b_in_ready) begin
      qb.push_back(ref_sub(b_in0, b_in1, b_bin));
      acc_b++;
      if (stream_b && last_b >= 0) check_eq("b_interval", 64'(cyc - last_b), 64'd3);
      last_b = cyc;
    end
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        check_eq("b_spurious_out", 64'(b_out_valid), 64'd0);
      end else begin
        eb = qb.pop_front();
        check_eq("b_result", 64'({b_bout, b_diff}), 64'(eb[32:0]));
`ifdef SUB_SEQ_FLAGS_EN
        check_eq("b_flags", 64'({b_ovf, b_neg, b_zero}), 64'(eb[35:33]));
`endif
      end
    end
  end

  task automatic op_a(input logic [31:0] x, input logic [31:0] y, input logic bi);
    int n = 0;
    while (!a_in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check_eq("a_ready_timeout", 64'(a_in_ready), 64'd1);
    a_in0 = x; a_in1 = y; a_bin = bi; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic op_b(input logic [31:0] x, input logic [31:0] y, input logic bi);
    int n = 0;
    while (!b_in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check_eq("b_ready_timeout", 64'(b_in_ready), 64'd1);
    b_in0 = x; b_in1 = y; b_bin = bi; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while ((qa.size() != 0 || !a_in_ready) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check_eq("a_drain", 64'(qa.size()), 64'd0);
  endtask

  task automatic drain_b();
    int n = 0;
    while ((qb.size() != 0 || !b_in_ready) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check_eq("b_drain", 64'(qb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in0 = '0; a_in1 = '0; a_bin = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in0 = '0; b_in1 = '0; b_bin = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(a_in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(a_out_valid), 64'd0);
    check_eq("rst_diff_bout", 64'({a_bout, a_diff}), 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("idle_in_ready", 64'(a_in_ready), 64'd1);

    // Basic op and 8-cycle latency
    op_a(32'h0000_0010, 32'h0000_0001, 1'b0);
    n = 0;
    while (!a_out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_eq("latency_a", 64'(n), 64'd8);
    check_eq("t1_diff", 64'({a_bout, a_diff}), 64'h0_0000_000F);
    drain_a();

    // Borrow wrap-around cases
    op_a(32'h0000_0000, 32'h0000_0001, 1'b0);
    op_a(32'h0000_0005, 32'h0000_0005, 1'b1);
    drain_a();

    // Backpressure: result held, no second accept
    a_out_ready = 1'b0;
    op_a(32'h0000_0100, 32'h0000_0001, 1'b0);
    n = 0;
    while (!a_out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    a_in0 = 32'hAAAA_AAAA; a_in1 = 32'h1; a_in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check_eq("bp_out_valid", 64'(a_out_valid), 64'd1);
      check_eq("bp_in_ready", 64'(a_in_ready), 64'd0);
      check_eq("bp_hold", 64'({a_bout, a_diff}), 64'h0_0000_00FF);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check_eq("bp_release_valid", 64'(a_out_valid), 64'd0);
    check_eq("bp_release_ready", 64'(a_in_ready), 64'd1);
    check_eq("bp_no_accept", 64'(qa.size()), 64'd0);
    a_out_ready = 1'b1;

    // Reset while processing chunk 3
    op_a(32'hFFFF_0000, 32'h0000_0001, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
    check_eq("mid_rst_in_ready", 64'(a_in_ready), 64'd0);
    check_eq("mid_rst_diff", 64'(a_diff), 64'd0);
    qa.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", 64'(a_in_ready), 64'd1);
    op_a(32'h1234_5678, 32'h0234_5678, 1'b0);
    drain_a();

    // Signed overflow and zero results
    op_a(32'h8000_0000, 32'h0000_0001, 1'b0);
    op_a(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    drain_a();

    // Back-to-back random stream, CHUNK=4
    stream_a = 1'b1; last_a = -1; acc0 = acc_a; n = 0;
    a_in_valid = 1'b1;
    while (acc_a - acc0 < 1000 && n < 15000) begin
      a_in0 = $urandom; a_in1 = $urandom; a_bin = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    a_in_valid = 1'b0;
    stream_a = 1'b0;
    check_eq("a_stream_ops", 64'(acc_a - acc0), 64'd1000);
    drain_a();

    // CHUNK=32: single-cycle latency, then random stream
    op_b(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
    n = 0;
    while (!b_out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_eq("latency_b", 64'(n), 64'd1);
    drain_b();
    stream_b = 1'b1; last_b = -1; acc0 = acc_b; n = 0;
    b_in_valid = 1'b1;
    while (acc_b - acc0 < 1000 && n < 5000) begin
      b_in0 = $urandom; b_in1 = $urandom; b_bin = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    b_in_valid = 1'b0;
    stream_b = 1'b0;
    check_eq("b_stream_ops", 64'(acc_b - acc0), 64'd1000);
    drain_b();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
